multi_clk_en_gen: RTL and testbench

MULTI_CLK_EN_GEN -- requirements
Module: multi_clk_en_gen

---
 rtl/multi_clk_en_gen_pkg.sv | 12 +
 rtl/clk_en_chan.sv | 69 ++++++
 rtl/multi_clk_en_gen.sv | 86 ++++++++
 tb/tb_multi_clk_en_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_clk_en_gen_pkg.sv
// rtl/multi_clk_en_gen_pkg.sv - shared state type and constants for the clock-enable generator
package multi_clk_en_gen_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/clk_en_chan.sv
// rtl/clk_en_chan.sv - one divided-clock channel: shadow value, counter, toggle, clk_en pulse
// Optional toggle statistics under MULTI_CLK_EN_GEN_STAT_EN.
module clk_en_chan
    import multi_clk_en_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic [CNT_W-1:0]  half_period,
    output logic              div_clk,
    output logic              clk_en
`ifdef MULTI_CLK_EN_GEN_STAT_EN
    ,
    output logic [STAT_W-1:0] toggle_cnt
`endif
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             active;
    logic             toggle;

    // last is only meaningful when shadow is non-zero, so the subtract never underflows in use
    assign last   = shadow - CNT_W'(1);
    assign active = run && (shadow != '0);
    assign toggle = active && (cnt == last);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            cnt     <= '0;
            div_clk <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            if (load) begin
                shadow <= half_period;
            end
            if (!active) begin
                cnt     <= '0;
                div_clk <= 1'b0;
                clk_en  <= 1'b0;
            end else if (toggle) begin
                cnt     <= '0;
                div_clk <= ~div_clk;
                clk_en  <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                clk_en  <= 1'b0;
            end
        end
    end

`ifdef MULTI_CLK_EN_GEN_STAT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            toggle_cnt <= '0;
        end else if (load) begin
            toggle_cnt <= '0;
        end else if (toggle && (toggle_cnt != '1)) begin
            toggle_cnt <= toggle_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/multi_clk_en_gen.sv
// rtl/multi_clk_en_gen.sv - multi-channel clock-enable generator with stretched reset
// Optional toggle_cnt statistics port under MULTI_CLK_EN_GEN_STAT_EN.
module multi_clk_en_gen
    import multi_clk_en_gen_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     load,
    input  logic [CH_NUM*CNT_W-1:0]  half_period,
    output logic [CH_NUM-1:0]        div_clk,
    output logic [CH_NUM-1:0]        clk_en,
    output logic                     sys_rst,
    output logic                     running
`ifdef MULTI_CLK_EN_GEN_STAT_EN
    ,
    output logic [CH_NUM*STAT_W-1:0] toggle_cnt
`endif
);

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
    logic       run_ch;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            sys_rst  <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            sys_rst  <= (state_nxt == HOLD);
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = IDLE;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            IDLE: if (enable)  state_nxt = RUN;
            RUN:  if (!enable) state_nxt = IDLE;
            default: state_nxt = HOLD;
        endcase
    end

    assign running = (state == RUN);

    // Channels clear on the same edge that leaves RUN or reloads, so the next cycle is already phase zero
    assign run_ch = (state == RUN) && enable && !load;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        clk_en_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clock       (clock),
            .rst         (rst),
            .load        (load),
            .run         (run_ch),
            .half_period (half_period[i*CNT_W +: CNT_W]),
            .div_clk     (div_clk[i]),
            .clk_en      (clk_en[i])
`ifdef MULTI_CLK_EN_GEN_STAT_EN
            ,
            .toggle_cnt  (toggle_cnt[i*STAT_W +: STAT_W])
`endif
        );
    end

endmodule

// File: tb/tb_multi_clk_en_gen.sv
// tb/tb_multi_clk_en_gen.sv - directed self-checking bench for multi_clk_en_gen (MULTI_CLK_EN_GEN_STAT_EN aware)
module tb_multi_clk_en_gen;

    logic        clock;
    logic        rst;
    logic        enable;
    logic        load;
    logic [63:0] half_period;
    logic [3:0]  div_clk;
    logic [3:0]  clk_en;
    logic        sys_rst;
    logic        running;
`ifdef MULTI_CLK_EN_GEN_STAT_EN
    logic [127:0] toggle_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n;
    logic [3:0] ed;
    logic [3:0] ee;

    multi_clk_en_gen #(
        .CH_NUM   (4),
        .CNT_W    (16),
        .RST_HOLD (16)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .half_period (half_period),
        .div_clk     (div_clk),
        .clk_en      (clk_en),
        .sys_rst     (sys_rst),
        .running     (running)
`ifdef MULTI_CLK_EN_GEN_STAT_EN
        ,
        .toggle_cnt  (toggle_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        load        = 1'b0;
        half_period = '0;
        tick();
        tick();
        chk("rst_sys_rst", 64'(sys_rst), 64'd1);
        chk("rst_div_clk", 64'(div_clk), 64'd0);
        chk("rst_clk_en",  64'(clk_en),  64'd0);
        chk("rst_running", 64'(running), 64'd0);

        // Reset stretch length
        rst = 1'b0;
        n = 0;
        while (sys_rst === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("hold_len",     64'(n),       64'd16);
        chk("hold_to_idle", 64'(running), 64'd0);

        // Unloaded channels stay quiet in RUN
        enable = 1'b1;
        tick();
        chk("run_entry", 64'(running), 64'd1);
        repeat (3) tick();
        chk("unloaded_div", 64'(div_clk), 64'd0);
        chk("unloaded_en",  64'(clk_en),  64'd0);
        enable = 1'b0;
        tick();
        chk("idle_exit", 64'(running), 64'd0);

        // ch0=1, ch1=3, ch2=0, ch3=65535
        half_period = {16'd65535, 16'd0, 16'd3, 16'd1};
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("load_idle_div", 64'(div_clk), 64'd0);
        enable = 1'b1;
        tick();
        chk("run1_running", 64'(running), 64'd1);
        chk("run1_div0",    64'(div_clk), 64'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            ed = 4'b0000;
            ee = 4'b0001;
            ed[0] = (k % 2) == 1;
            ed[1] = ((k / 3) % 2) == 1;
            ee[1] = (k % 3) == 0;
            chk($sformatf("run1_div k=%0d", k), 64'(div_clk), 64'(ed));
            chk($sformatf("run1_en k=%0d", k),  64'(clk_en),  64'(ee));
        end
        repeat (65534 - 12) tick();
        chk("ch3_before_div", 64'(div_clk[3]), 64'd0);
        chk("ch3_before_en",  64'(clk_en[3]),  64'd0);
        tick();
        chk("ch3_toggle_div", 64'(div_clk[3]), 64'd1);
        chk("ch3_toggle_en",  64'(clk_en[3]),  64'd1);

        // Reload during RUN: ch1=5
        half_period = {16'd65535, 16'd0, 16'd5, 16'd1};
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("reload_div",     64'(div_clk), 64'd0);
        chk("reload_en",      64'(clk_en),  64'd0);
        chk("reload_running", 64'(running), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            ed = 4'b0000;
            ee = 4'b0001;
            ed[0] = (k % 2) == 1;
            ed[1] = (k == 5);
            ee[1] = (k == 5);
            chk($sformatf("reload_div k=%0d", k), 64'(div_clk), 64'(ed));
            chk($sformatf("reload_en k=%0d", k),  64'(clk_en),  64'(ee));
        end

        // Drop enable mid-period, then re-enable
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("drop_running", 64'(running), 64'd0);
        chk("drop_div",     64'(div_clk), 64'd0);
        chk("drop_en",      64'(clk_en),  64'd0);
        enable = 1'b1;
        tick();
        chk("reen_running", 64'(running), 64'd1);
        repeat (4) tick();
        chk("reen_ch1_k4", 64'(div_clk[1]), 64'd0);
        tick();
        chk("reen_ch1_k5_div", 64'(div_clk[1]), 64'd1);
        chk("reen_ch1_k5_en",  64'(clk_en[1]),  64'd1);

        // load together with enable fall: IDLE wins, value still latched (ch1=2)
        half_period = {16'd65535, 16'd0, 16'd2, 16'd1};
        load   = 1'b1;
        enable = 1'b0;
        tick();
        load = 1'b0;
        chk("ld_drop_running", 64'(running), 64'd0);
        chk("ld_drop_div",     64'(div_clk), 64'd0);
        enable = 1'b1;
        tick();
        tick();
        chk("ld_drop_ch1_k1", 64'(div_clk[1]), 64'd0);
        tick();
        chk("ld_drop_ch1_k2", 64'(div_clk[1]), 64'd1);

        // Asynchronous reset mid-RUN
        tick();
        chk("pre_rst_div0", 64'(div_clk[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_div",     64'(div_clk), 64'd0);
        chk("arst_en",      64'(clk_en),  64'd0);
        chk("arst_running", 64'(running), 64'd0);
        chk("arst_sys_rst", 64'(sys_rst), 64'd1);
        tick();
        rst = 1'b0;
        n = 0;
        while (sys_rst === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("hold2_len",     64'(n),       64'd16);
        chk("hold2_running", 64'(running), 64'd0);
        tick();
        chk("hold2_run", 64'(running), 64'd1);
        repeat (3) tick();
        chk("post_rst_shadow_cleared", 64'(div_clk), 64'd0);

`ifdef MULTI_CLK_EN_GEN_STAT_EN
        half_period = {48'd0, 16'd2};
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (100) tick();
        chk("stat_ch0_50", 64'(toggle_cnt[31:0]),  64'd50);
        chk("stat_ch1_0",  64'(toggle_cnt[63:32]), 64'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("stat_cleared", 64'(toggle_cnt[31:0]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
